demux_sel_sequencer: RTL and testbench
======================================

// Module: demux_sel_sequencer
// PURPOSE
//   Upstream driver for the 1-to-8 bit demux stage. Accepts bytes over a
//   valid/ready handshake and serialises each one bit-per-cycle.
//   For each bit it presents din plus the matching 3-bit sel, so the demux
//   steers bit k onto lane k. It also flags bit validity and frame completion.
// PARAMETERS
//   GAP_CYCLES  0  idle cycles inserted after each frame (legal 0..15)
// PORTS
//   clk         in   1  single clock, rising-edge
//   rst         in   1  asynchronous, active-high reset
//   in_data     in   8  byte to serialise
//   in_valid    in   1  in_data valid
//   in_ready    out  1  sequencer can accept a byte this cycle
//   abort       in   1  synchronous frame abort
//   din         out  1  serial bit to demux din
//   sel         out  3  lane index to demux sel
//   bit_valid   out  1  din/sel are meaningful this cycle
//   frame_done  out  1  one-cycle pulse coincident with the last bit of a frame
//   busy        out  1  frame in progress (SHIFT or GAP)
// BEHAVIOUR
//   Interface: one clock (clk); rst asynchronous, active-high.
//   Reset values: state=IDLE, din=0, sel=0, bit_valid=0, frame_done=0, busy=0,
//     shift reg=0, counters=0. in_ready=0 while rst is high.
//   Reset is asynchronous: asserting rst mid-frame forces all outputs to their
//     reset values immediately. The partial frame is discarded.
//   FSM states: IDLE, SHIFT, GAP. din, sel, bit_valid and frame_done are registered.
//   IDLE:  in_ready=1. On in_valid&&in_ready, capture in_data, set idx to the
//     first index, go to SHIFT.
//   SHIFT: each cycle: din=data[idx], sel=idx, bit_valid=1, busy=1.
//     Latency: first bit appears 1 cycle after the accepting edge.
//     A frame is exactly 8 consecutive bit_valid cycles.
//     Index order is ascending, 0..7.
//     On the last bit, frame_done=1. Next state is GAP if GAP_CYCLES>0,
//     otherwise IDLE.
//   Back-to-back: when GAP_CYCLES==0, in_ready is also 1 during the last SHIFT
//     cycle. A byte accepted there goes straight to SHIFT, giving 8-cycle
//     throughput with no bubble.
//   GAP: bit_valid=0, busy=1, in_ready=0. Lasts exactly GAP_CYCLES cycles,
//     then goes to IDLE.
//   in_data / in_valid changes outside an accept edge are ignored.
//     The captured byte is held until the frame ends.
//   abort (SHIFT or GAP): go to IDLE next edge with bit_valid=0 and busy=0.
//     No frame_done. abort in IDLE has no effect.
//   abort has priority over accept in the same cycle.
//   sel/din hold their last values when bit_valid=0. Downstream must qualify
//     with bit_valid.
//   The idx counter is 3-bit and wraps 7->0. The wrap is never observed
//     within a frame.
// CONFIGURATION
//   DEMUX_SEQ_MSB_FIRST_EN defined: index order is descending, 7..0.
//     frame_done coincides with sel=0.
//   Not defined: ascending, 0..7. frame_done coincides with sel=7.
//   Lane mapping is unchanged either way: sel always equals the bit index.
// TESTING
//   1. Reset, then send 8'hA5 (GAP=0) -> 8 cycles later sel=0..7,
//      din=1,0,1,0,0,1,0,1, frame_done on sel=7; then in_ready=1.
//   2. 8'hFF then 8'h00 held valid back-to-back (GAP=0) -> 16 contiguous
//      bit_valid cycles, with din switching 1->0 exactly at the frame boundary.
//   3. GAP_CYCLES=3, two bytes -> exactly 3 cycles with bit_valid=0 and busy=1
//      between the frames; in_ready=0 throughout.
//   4. abort at sel=4 of 8'h3C -> bit_valid=0 next cycle, no frame_done,
//      in_ready=1; the next byte is serialised in full.
//   5. rst asserted at sel=2 -> bit_valid, busy and frame_done drop
//      asynchronously; after release, 8'h81 serialises correctly.
//   6. DEMUX_SEQ_MSB_FIRST_EN, 8'h81 -> sel=7..0, din=1,0,0,0,0,0,0,1,
//      frame_done on sel=0.

Source files
------------

// File: rtl/demux_sel_sequencer.sv
`timescale 1ns/1ps
// demux_sel_sequencer
// Serialises one byte per frame, one bit per clock, driving din plus a
// lane index (sel) for a downstream 1-to-8 demux. GAP_CYCLES idle cycles
// (0..15) may follow each frame.
// Optional build macro: DEMUX_SEQ_MSB_FIRST_EN selects descending bit order
// (7..0) instead of the default ascending order (0..7).
module demux_sel_sequencer #(
    parameter int GAP_CYCLES = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       abort,
    output logic       din,
    output logic [2:0] sel,
    output logic       bit_valid,
    output logic       frame_done,
    output logic       busy
);

`ifdef DEMUX_SEQ_MSB_FIRST_EN
    localparam logic [2:0] FIRST_IDX = 3'd7;
    localparam logic [2:0] LAST_IDX  = 3'd0;
    localparam logic [2:0] IDX_STEP  = 3'd7;  // -1 modulo 8
`else
    localparam logic [2:0] FIRST_IDX = 3'd0;
    localparam logic [2:0] LAST_IDX  = 3'd7;
    localparam logic [2:0] IDX_STEP  = 3'd1;
`endif

    localparam bit         HAS_GAP  = (GAP_CYCLES > 0);
    localparam logic [3:0] GAP_LAST = HAS_GAP ? 4'(GAP_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t     r_state;
    logic [7:0] r_data;
    logic [2:0] r_idx;
    logic [3:0] r_gap_cnt;
    logic       r_din;
    logic       r_bit_valid;
    logic       r_frame_done;

    state_t     w_state_next;
    logic [7:0] w_data_next;
    logic [2:0] w_idx_next;
    logic [3:0] w_gap_cnt_next;
    logic       w_din_next;
    logic       w_bit_valid_next;
    logic       w_frame_done_next;

    logic       w_ready;
    logic       w_accept;
    logic       w_is_last;
    logic [2:0] w_idx_step;

    // r_idx always holds the index of the bit currently on din
    assign w_is_last  = (r_idx == LAST_IDX);
    assign w_idx_step = r_idx + IDX_STEP;

    // Ready in IDLE, and on the final bit when frames may run back-to-back;
    // a same-cycle abort withdraws that late ready so no byte is lost
    always_comb begin
        w_ready = 1'b0;
        case (r_state)
            ST_IDLE:  w_ready = 1'b1;
            ST_SHIFT: w_ready = !HAS_GAP && w_is_last && !abort;
            default:  w_ready = 1'b0;
        endcase
    end

    assign w_accept = in_valid && w_ready;

    // Next-state and next-output decode
    always_comb begin
        w_state_next      = r_state;
        w_data_next       = r_data;
        w_idx_next        = r_idx;
        w_gap_cnt_next    = r_gap_cnt;
        w_din_next        = r_din;
        w_bit_valid_next  = 1'b0;
        w_frame_done_next = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_next     = ST_SHIFT;
                    w_data_next      = in_data;
                    w_idx_next       = FIRST_IDX;
                    w_din_next       = in_data[FIRST_IDX];
                    w_bit_valid_next = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (abort) begin
                    w_state_next = ST_IDLE;
                end else if (!w_is_last) begin
                    w_idx_next        = w_idx_step;
                    w_din_next        = r_data[w_idx_step];
                    w_bit_valid_next  = 1'b1;
                    w_frame_done_next = (w_idx_step == LAST_IDX);
                end else if (w_accept) begin
                    // back-to-back: next frame starts with no bubble
                    w_data_next      = in_data;
                    w_idx_next       = FIRST_IDX;
                    w_din_next       = in_data[FIRST_IDX];
                    w_bit_valid_next = 1'b1;
                end else if (HAS_GAP) begin
                    w_state_next   = ST_GAP;
                    w_gap_cnt_next = 4'd0;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_GAP: begin
                if (abort || (r_gap_cnt == GAP_LAST)) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_gap_cnt_next = r_gap_cnt + 4'd1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs, cleared immediately on rst
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_data       <= 8'd0;
            r_idx        <= 3'd0;
            r_gap_cnt    <= 4'd0;
            r_din        <= 1'b0;
            r_bit_valid  <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_data       <= w_data_next;
            r_idx        <= w_idx_next;
            r_gap_cnt    <= w_gap_cnt_next;
            r_din        <= w_din_next;
            r_bit_valid  <= w_bit_valid_next;
            r_frame_done <= w_frame_done_next;
        end
    end

    assign in_ready   = w_ready && !rst;
    assign din        = r_din;
    assign sel        = r_idx;
    assign bit_valid  = r_bit_valid;
    assign frame_done = r_frame_done;
    assign busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_demux_sel_sequencer.sv
`timescale 1ns/1ps
// Bench for demux_sel_sequencer: two instances (GAP_CYCLES 0 and 3) share
// stimulus; a frame-level model predicts every output on every cycle, and
// directed scenarios pin the model with literal expectations.
module tb_demux_sel_sequencer;

`ifdef DEMUX_SEQ_MSB_FIRST_EN
    localparam logic [23:0] SEL_SEQ = {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
    localparam bit MSB_FIRST = 1'b1;
`else
    localparam logic [23:0] SEL_SEQ = {3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
    localparam bit MSB_FIRST = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] in_data = 8'd0;
    logic       in_valid = 1'b0;
    logic       abort = 1'b0;
    logic [1:0] in_ready, din, bit_valid, frame_done, busy;
    logic [2:0] sel0, sel1;

    int n_checks = 0;
    int n_fail   = 0;

    demux_sel_sequencer #(.GAP_CYCLES(0)) u_g0 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready[0]), .abort(abort), .din(din[0]), .sel(sel0),
        .bit_valid(bit_valid[0]), .frame_done(frame_done[0]), .busy(busy[0])
    );

    demux_sel_sequencer #(.GAP_CYCLES(3)) u_g3 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready[1]), .abort(abort), .din(din[1]), .sel(sel1),
        .bit_valid(bit_valid[1]), .frame_done(frame_done[1]), .busy(busy[1])
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    function automatic logic [2:0] sel_of(input int inst);
        return (inst == 0) ? sel0 : sel1;
    endfunction

    // ---------------- frame-level reference model ----------------
    int         gcfg [2] = '{0, 3};
    bit         m_valid [2];
    bit         m_din [2];
    bit         m_fd [2];
    logic [2:0] m_sel [2];
    logic [7:0] m_data [2];
    int         m_rem [2];   // bits still to come after the one shown
    int         m_gap [2];   // idle cycles still to show

    // lane carrying the bit at position pos (0 = first) within a frame
    function automatic logic [2:0] lane(input int pos);
        return MSB_FIRST ? 3'(7 - pos) : 3'(pos);
    endfunction

    function automatic bit m_ready(input int i);
        bit idle;
        idle = !m_valid[i] && (m_gap[i] == 0);
        return !rst && (idle || (gcfg[i] == 0 && m_valid[i] && m_rem[i] == 0 && !abort));
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 2; i++) begin
            m_valid[i] = 0; m_din[i] = 0; m_fd[i] = 0; m_sel[i] = 3'd0;
            m_data[i] = 8'd0; m_rem[i] = 0; m_gap[i] = 0;
        end
    endtask

    task automatic m_step(input int i);
        bit r;
        r = m_ready(i);
        if (abort && (m_valid[i] || m_gap[i] > 0)) begin
            m_valid[i] = 0; m_fd[i] = 0; m_rem[i] = 0; m_gap[i] = 0;
        end else if (in_valid && r) begin
            m_data[i] = in_data; m_rem[i] = 7; m_sel[i] = lane(0);
            m_din[i] = in_data[lane(0)]; m_valid[i] = 1; m_fd[i] = 0;
        end else if (m_valid[i]) begin
            if (m_rem[i] > 0) begin
                m_rem[i]--;
                m_sel[i] = lane(7 - m_rem[i]);
                m_din[i] = m_data[i][m_sel[i]];
                m_fd[i]  = (m_rem[i] == 0);
            end else begin
                m_valid[i] = 0; m_fd[i] = 0; m_gap[i] = gcfg[i];
            end
        end else if (m_gap[i] > 0) begin
            m_gap[i]--;
        end
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) m_reset();
            else for (int i = 0; i < 2; i++) m_step(i);
        end
    end

    // ---------------- per-cycle comparison against the model ----------------
    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                check($sformatf("bit_valid[%0d]", i), int'(bit_valid[i]), int'(m_valid[i]));
                check($sformatf("frame_done[%0d]", i), int'(frame_done[i]), int'(m_fd[i]));
                check($sformatf("busy[%0d]", i), int'(busy[i]), int'(m_valid[i] || m_gap[i] > 0));
                check($sformatf("in_ready[%0d]", i), int'(in_ready[i]), int'(m_ready(i)));
                check($sformatf("din[%0d]", i), int'(din[i]), int'(m_din[i]));
                check($sformatf("sel[%0d]", i), int'(sel_of(i)), int'(m_sel[i]));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // hold a byte valid until instance inst accepts it; returns while its first bit shows
    task automatic send(input logic [7:0] b, input int inst);
        bit got;
        got = 0;
        in_valid = 1'b1;
        in_data  = b;
        for (int k = 0; k < 100 && !got; k++) begin
            @(negedge clk);
            if (in_ready[inst]) got = 1;
            tick();
        end
        in_valid = 1'b0;
        check("send_accept_timeout", int'(got), 1);
    endtask

    task automatic capture(input int inst, input int n, output logic [31:0] dv,
                           output logic [31:0] vv, output logic [47:0] sv, output int fdpos);
        dv = 0; vv = 0; sv = 0; fdpos = -1;
        for (int k = 0; k < n; k++) begin
            vv = {vv[30:0], bit_valid[inst]};
            if (bit_valid[inst]) begin
                dv = {dv[30:0], din[inst]};
                sv = {sv[44:0], sel_of(inst)};
            end
            if (frame_done[inst] && fdpos < 0) fdpos = k;
            tick();
        end
    endtask

    task automatic wait_sel(input int inst, input logic [2:0] s);
        bit found;
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (bit_valid[inst] && sel_of(inst) == s) found = 1;
            else tick();
        end
        check("wait_sel_timeout", int'(found), 1);
    endtask

    // ---------------- directed scenarios, then random traffic ----------------
    initial begin
        logic [31:0] dv, vv;
        logic [47:0] sv;
        int          fdpos, gapc, rdyg, vcnt;

        #1;
        rst = 1'b1;
        #1;
        check("rst_in_ready", int'(in_ready[0]), 0);
        check("rst_bit_valid", int'(bit_valid[0]), 0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", int'(in_ready[0]), 1);
        check("post_rst_busy", int'(busy[0]), 0);
        check("post_rst_sel", int'(sel0), 0);

        // single byte, GAP=0
        send(8'hA5, 0);
        capture(0, 8, dv, vv, sv, fdpos);
        check("a5_din_seq", int'(dv[7:0]), 8'hA5);
        check("a5_sel_seq", int'(sv[23:0]), int'(SEL_SEQ));
        check("a5_valid_run", int'(vv[7:0]), 8'hFF);
        check("a5_fd_pos", fdpos, 7);
        check("a5_after_ready", int'(in_ready[0]), 1);
        check("a5_after_valid", int'(bit_valid[0]), 0);

        // back-to-back FF then 00, GAP=0
        tick();
        tick();
        tick();
        send(8'hFF, 0);
        fork
            send(8'h00, 0);
            capture(0, 17, dv, vv, sv, fdpos);
        join
        check("b2b_valid_run", int'(vv[16:0]), 17'h1FFFE);
        check("b2b_din_seq", int'(dv[15:0]), 16'hFF00);

        // GAP=3 between two frames
        do_reset();
        send(8'h11, 1);
        gapc = 0; rdyg = 0; vcnt = 0;
        fork
            send(8'h22, 1);
            for (int k = 0; k < 20; k++) begin
                if (busy[1] && !bit_valid[1]) begin
                    gapc++;
                    if (in_ready[1]) rdyg++;
                end
                if (bit_valid[1]) vcnt++;
                tick();
            end
        join
        check("gap_cycles", gapc, 3);
        check("gap_ready_seen", rdyg, 0);
        check("gap_valid_total", vcnt, 16);

        // abort at sel=4
        do_reset();
        send(8'h3C, 0);
        wait_sel(0, 3'd4);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_bit_valid", int'(bit_valid[0]), 0);
        check("abort_busy", int'(busy[0]), 0);
        check("abort_fd", int'(frame_done[0]), 0);
        check("abort_ready", int'(in_ready[0]), 1);
        send(8'h5A, 0);
        capture(0, 8, dv, vv, sv, fdpos);
        check("post_abort_din", int'(dv[7:0]), 8'h5A);
        check("post_abort_valid", int'(vv[7:0]), 8'hFF);
        check("post_abort_fd_pos", fdpos, 7);

        // asynchronous reset at sel=2
        do_reset();
        send(8'h0F, 0);
        wait_sel(0, 3'd2);
        #2;
        rst = 1'b1;
        #1;
        check("arst_bit_valid", int'(bit_valid[0]), 0);
        check("arst_busy", int'(busy[0]), 0);
        check("arst_fd", int'(frame_done[0]), 0);
        check("arst_ready", int'(in_ready[0]), 0);
        tick();
        rst = 1'b0;
        send(8'h81, 0);
        capture(0, 8, dv, vv, sv, fdpos);
        check("post_rst_81_din", int'(dv[7:0]), 8'h81);
        check("post_rst_81_sel", int'(sv[23:0]), int'(SEL_SEQ));
        check("post_rst_81_fd_pos", fdpos, 7);

        // random traffic: model checks every cycle
        for (int k = 0; k < 3000; k++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = 8'($urandom);
            abort    = ($urandom_range(0, 19) == 0);
            rst      = ($urandom_range(0, 249) == 0);
            tick();
        end
        in_valid = 1'b0;
        abort    = 1'b0;
        rst      = 1'b0;
        repeat (20) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
